cam_pix_capture: RTL and testbench

CAM_PIX_CAPTURE -- requirements
Module: cam_pix_capture

---
 rtl/cam_pix_capture.sv | 173 +++++++++++++++++
 tb/tb_cam_pix_capture.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pix_capture.sv
// Camera pixel capture: syncs CAM_* inputs, packs beats into pixels, crops them and
// emits line-buffer writes two stages after the input register, with ping-pong banking.
module cam_pix_capture #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int ADDR_W        = 10,
  parameter int LINE_W        = 9,
  parameter bit VS_POL        = 1'b1,
  parameter bit HREF_POL      = 1'b1
) (
  input  logic                            PCLK,
  input  logic                            RST_N,
  input  logic                            CAM_VSYNC,
  input  logic                            CAM_HREF,
  input  logic [DATA_W-1:0]               CAM_DATA,
  input  logic                            CAPTURE_EN,
  input  logic                            ERR_CLR,
  input  logic [ADDR_W:0]                 CROP_X0,
  input  logic [ADDR_W:0]                 CROP_X1,
  input  logic [LINE_W-1:0]               CROP_Y0,
  input  logic [LINE_W-1:0]               CROP_Y1,
  output logic                            LB_WR_EN,
  output logic [ADDR_W-1:0]               LB_WR_ADDR,
  output logic [BYTES_PER_PIX*DATA_W-1:0] LB_WR_DATA,
  output logic                            LB_BANK,
  output logic                            LINE_DONE,
  output logic                            FRAME_START,
  output logic                            FRAME_DONE,
  output logic [LINE_W-1:0]               LINE_CNT,
  output logic [15:0]                     FRAME_CNT,
  output logic                            ERR_OVF,
  output logic                            ERR_PARTIAL
);
  localparam int PW = BYTES_PER_PIX * DATA_W;
  localparam int XW = ADDR_W + 1;
  localparam logic [1:0] LAST_PH = 2'(BYTES_PER_PIX - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, FRAME} state_t;
  state_t state, stateNxt;

  logic              vsR, vsD, hrefR, hrefD;
  logic [DATA_W-1:0] dataR;
  logic [XW-1:0]     cropX0, cropX1, pixIdx, curIdx, offset;
  logic [LINE_W-1:0] cropY0, cropY1;
  logic [1:0]        phase, curPhase;
  logic [PW-1:0]     acc, accNxt, s1Data;
  logic [ADDR_W-1:0] s1Addr;
  logic              s1Wr, lineEndPend;
  logic              vsRise, vsFall, hrefRise, hrefFall, startFrame, endFrame;
  logic              pixDone, inY, xOk, inWin, wrHit, ovfHit, lineEnd, partial;

  // Input register holds polarity-normalised syncs; reset value 0 means inactive.
  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      vsR   <= 1'b0;
      vsD   <= 1'b0;
      hrefR <= 1'b0;
      hrefD <= 1'b0;
      dataR <= '0;
    end else begin
      vsR   <= (CAM_VSYNC == VS_POL);
      vsD   <= vsR;
      hrefR <= (CAM_HREF == HREF_POL);
      hrefD <= hrefR;
      dataR <= CAM_DATA;
    end
  end

  assign vsRise   = vsR & ~vsD;
  assign vsFall   = ~vsR & vsD;
  assign hrefRise = hrefR & ~hrefD;
  assign hrefFall = ~hrefR & hrefD;

  always_comb begin
    stateNxt   = state;
    startFrame = 1'b0;
    endFrame   = 1'b0;
    case (state)
      IDLE:    if (CAPTURE_EN) stateNxt = WAIT_VS;
      WAIT_VS: begin
        if (!CAPTURE_EN) stateNxt = IDLE;
        else if (vsFall) begin
          stateNxt   = FRAME;
          startFrame = 1'b1;
        end
      end
      FRAME:   if (vsRise) begin
        stateNxt = IDLE;
        endFrame = 1'b1;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Stage 1: beat packing and crop decision on the pixel's final beat.
  assign curPhase = hrefRise ? 2'd0 : phase;
  assign curIdx   = hrefRise ? '0 : pixIdx;
  assign pixDone  = hrefR && (curPhase == LAST_PH);
  assign accNxt   = PW'({acc, dataR});
  assign offset   = curIdx - cropX0;
  assign inY      = (LINE_CNT >= cropY0) && (LINE_CNT <= cropY1);
  assign xOk      = cropX0 <= cropX1;
  assign inWin    = (state == FRAME) && inY && (curIdx >= cropX0) && (curIdx <= cropX1);
  assign wrHit    = pixDone && inWin && !offset[ADDR_W];
  assign ovfHit   = pixDone && inWin && offset[ADDR_W];
  assign lineEnd  = hrefFall && (state == FRAME);
  assign partial  = lineEnd && (phase != 2'd0);

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      acc         <= '0;
      phase       <= 2'd0;
      pixIdx      <= '0;
      s1Wr        <= 1'b0;
      s1Addr      <= '0;
      s1Data      <= '0;
      lineEndPend <= 1'b0;
      cropX0      <= '0;
      cropX1      <= '0;
      cropY0      <= '0;
      cropY1      <= '0;
      LB_WR_EN    <= 1'b0;
      LB_WR_ADDR  <= '0;
      LB_WR_DATA  <= '0;
      LB_BANK     <= 1'b0;
      LINE_DONE   <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_DONE  <= 1'b0;
      LINE_CNT    <= '0;
      FRAME_CNT   <= '0;
      ERR_OVF     <= 1'b0;
      ERR_PARTIAL <= 1'b0;
    end else begin
      state <= stateNxt;
      if (hrefR) begin
        acc    <= accNxt;
        phase  <= pixDone ? 2'd0 : curPhase + 2'd1;
        pixIdx <= (pixDone && curIdx != '1) ? curIdx + XW'(1) : curIdx;
      end
      s1Wr <= wrHit;
      if (wrHit) begin
        s1Addr <= offset[ADDR_W-1:0];
        s1Data <= accNxt;
      end
      // Stage 2: write port; line-end is delayed to match so the bank flips after the last write.
      LB_WR_EN <= s1Wr;
      if (s1Wr) begin
        LB_WR_ADDR <= s1Addr;
        LB_WR_DATA <= s1Data;
      end
      lineEndPend <= lineEnd && inY && xOk;
      LINE_DONE   <= lineEndPend;
      if (lineEndPend) LB_BANK <= ~LB_BANK;
      if (lineEnd && LINE_CNT != '1) LINE_CNT <= LINE_CNT + LINE_W'(1);
      FRAME_START <= startFrame;
      FRAME_DONE  <= endFrame;
      if (endFrame) FRAME_CNT <= FRAME_CNT + 16'd1;
      if (startFrame) begin
        LINE_CNT <= '0;
        LB_BANK  <= 1'b0;
        cropX0   <= CROP_X0;
        cropX1   <= CROP_X1;
        cropY0   <= CROP_Y0;
        cropY1   <= CROP_Y1;
      end
      if (ovfHit) ERR_OVF <= 1'b1;
      else if (ERR_CLR) ERR_OVF <= 1'b0;
      if (partial) ERR_PARTIAL <= 1'b1;
      else if (ERR_CLR) ERR_PARTIAL <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cam_pix_capture.sv
// Randomised bench for cam_pix_capture: a frame/line/pixel reference model predicts
// line-buffer writes, pulses and error flags, compared against a sampling monitor.
module tb_cam_pix_capture;
  localparam int BPP = 2;

  logic        PCLK = 1'b0, RST_N = 1'b0;
  logic        CAM_VSYNC = 1'b0, CAM_HREF = 1'b0;
  logic [7:0]  CAM_DATA = '0;
  logic        CAPTURE_EN = 1'b0, ERR_CLR = 1'b0;
  logic [10:0] CROP_X0 = '0, CROP_X1 = '0;
  logic [8:0]  CROP_Y0 = '0, CROP_Y1 = '0;
  logic        LB_WR_EN, LB_BANK, LINE_DONE, FRAME_START, FRAME_DONE, ERR_OVF, ERR_PARTIAL;
  logic [9:0]  LB_WR_ADDR;
  logic [15:0] LB_WR_DATA, FRAME_CNT;
  logic [8:0]  LINE_CNT;

  cam_pix_capture dut (
    .PCLK(PCLK), .RST_N(RST_N), .CAM_VSYNC(CAM_VSYNC), .CAM_HREF(CAM_HREF),
    .CAM_DATA(CAM_DATA), .CAPTURE_EN(CAPTURE_EN), .ERR_CLR(ERR_CLR),
    .CROP_X0(CROP_X0), .CROP_X1(CROP_X1), .CROP_Y0(CROP_Y0), .CROP_Y1(CROP_Y1),
    .LB_WR_EN(LB_WR_EN), .LB_WR_ADDR(LB_WR_ADDR), .LB_WR_DATA(LB_WR_DATA),
    .LB_BANK(LB_BANK), .LINE_DONE(LINE_DONE), .FRAME_START(FRAME_START),
    .FRAME_DONE(FRAME_DONE), .LINE_CNT(LINE_CNT), .FRAME_CNT(FRAME_CNT),
    .ERR_OVF(ERR_OVF), .ERR_PARTIAL(ERR_PARTIAL)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {int addr; int data; int bank; int cyc;} wr_t;
  wr_t obsQ[$], expQ[$];
  int  errors = 0, checks = 0;
  int  cyc = 0, obsLd = 0, obsFs = 0, obsFd = 0;
  int  mx0, mx1, my0, my1, mLine, mWin, expLd, expFs, expFd, expFc = 0, firstCyc = 0;
  bit  mActive = 0, expOvf = 0, expPart = 0, vsLvl = 0;

  // Monitor samples 1ns after each rising edge.
  always begin
    wr_t w;
    @(posedge PCLK);
    #1;
    cyc++;
    if (LB_WR_EN === 1'b1) begin
      w.addr = int'(LB_WR_ADDR); w.data = int'(LB_WR_DATA); w.bank = int'(LB_BANK); w.cyc = cyc;
      obsQ.push_back(w);
    end
    if (LINE_DONE === 1'b1) obsLd++;
    if (FRAME_START === 1'b1) obsFs++;
    if (FRAME_DONE === 1'b1) obsFd++;
  end

  task automatic drive(input bit href, input logic [7:0] d);
    @(negedge PCLK);
    CAM_VSYNC = vsLvl; CAM_HREF = href; CAM_DATA = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  task automatic begin_test();
    idle(4);
    obsQ.delete(); expQ.delete();
    obsLd = 0; obsFs = 0; obsFd = 0; expLd = 0; expFs = 0; expFd = 0;
  endtask

  task automatic clr_err();
    ERR_CLR = 1'b1; drive(1'b0, 8'h00); ERR_CLR = 1'b0;
    expOvf = 0; expPart = 0;
    idle(2);
  endtask

  task automatic set_crop(input int x0, input int x1, input int y0, input int y1);
    CROP_X0 = 11'(x0); CROP_X1 = 11'(x1); CROP_Y0 = 9'(y0); CROP_Y1 = 9'(y1);
  endtask

  // vsync pulse: ends an active frame, then starts one if capture is armed.
  task automatic vs_pulse();
    vsLvl = 1; idle(3);
    if (mActive) begin mActive = 0; expFd++; expFc++; end
    vsLvl = 0; idle(3);
    if (CAPTURE_EN) begin
      mActive = 1; mLine = 0; mWin = 0; expFs++;
      mx0 = int'(CROP_X0); mx1 = int'(CROP_X1); my0 = int'(CROP_Y0); my1 = int'(CROP_Y1);
    end
  endtask

  task automatic send_line(input int nBeats, input int abortAt, input bit forceAbcd);
    int pv;
    wr_t w;
    for (int p = 0; p * BPP < nBeats; p++) begin
      pv = (forceAbcd && p == 0) ? 32'hABCD : int'($urandom_range(0, 65535));
      if (p == abortAt) begin
        vsLvl = 1;
        if (mActive) begin mActive = 0; expFd++; expFc++; end
      end
      for (int b = 0; b < BPP && p * BPP + b < nBeats; b++) begin
        drive(1'b1, 8'(pv >> (8 * (BPP - 1 - b))));
        if (forceAbcd && p == 0 && b == BPP - 1) firstCyc = cyc;
      end
      if ((p + 1) * BPP <= nBeats && mActive && my0 <= mLine && mLine <= my1 &&
          mx0 <= p && p <= mx1) begin
        if (p - mx0 < 1024) begin
          w.addr = p - mx0; w.data = pv; w.bank = mWin % 2; w.cyc = 0;
          expQ.push_back(w);
        end else expOvf = 1;
      end
    end
    if (mActive) begin
      if (nBeats % BPP != 0) expPart = 1;
      if (my0 <= mLine && mLine <= my1 && mx0 <= mx1) begin expLd++; mWin++; end
      mLine++;
    end
    idle(4);
  endtask

  function automatic int wr_mismatch(output string msg);
    int n = 0;
    msg = "none";
    if (obsQ.size() != expQ.size()) begin
      n++;
      msg = $sformatf("write count %0d required %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++)
      if (obsQ[i].addr != expQ[i].addr || obsQ[i].data != expQ[i].data ||
          obsQ[i].bank != expQ[i].bank) begin
        if (n == 0)
          msg = $sformatf("write %0d got addr=%0d data=%h bank=%0d required addr=%0d data=%h bank=%0d",
                          i, obsQ[i].addr, obsQ[i].data, obsQ[i].bank,
                          expQ[i].addr, expQ[i].data, expQ[i].bank);
        n++;
      end
    return n;
  endfunction

  task automatic test_reset();
    idle(2);
    checks++;
    if ({LB_WR_EN, LB_WR_ADDR, LB_WR_DATA, LB_BANK, LINE_DONE, FRAME_START, FRAME_DONE} !== '0) begin
      errors++; $display("FAIL reset_strobes: got nonzero, required all 0");
    end
    checks++;
    if ({LINE_CNT, FRAME_CNT, ERR_OVF, ERR_PARTIAL} !== '0) begin
      errors++; $display("FAIL reset_counters: LINE_CNT=%0d FRAME_CNT=%0d errs=%b%b required 0",
                         LINE_CNT, FRAME_CNT, ERR_OVF, ERR_PARTIAL);
    end
    @(negedge PCLK); RST_N = 1'b1;
  endtask

  task automatic test_basic();
    string msg; int m;
    set_crop(0, 639, 0, 479);
    begin_test();
    CAPTURE_EN = 1'b1;
    vs_pulse();
    for (int l = 0; l < 12; l++) begin
      send_line(80, -1, l == 0);
      if (l == 2) CAPTURE_EN = 1'b0;
    end
    vs_pulse();
    idle(5);
    m = wr_mismatch(msg); checks++;
    if (m != 0) begin errors++; $display("FAIL basic_writes: %0d bad (%s), required 0", m, msg); end
    checks++;
    if (obsQ.size() == 0) begin errors++; $display("FAIL basic_first_write: got none, required one"); end
    else if (obsQ[0].cyc != firstCyc + 3 || obsQ[0].addr != 0 || obsQ[0].data != 32'hABCD) begin
      errors++;
      $display("FAIL basic_first_write: cyc=%0d addr=%0d data=%h required cyc=%0d addr=0 data=abcd",
               obsQ[0].cyc, obsQ[0].addr, obsQ[0].data, firstCyc + 3);
    end
    checks++;
    if (obsLd != expLd) begin errors++; $display("FAIL basic_line_done: got %0d required %0d", obsLd, expLd); end
    checks++;
    if (obsFs != 1 || obsFd != 1) begin
      errors++; $display("FAIL basic_frame_pulses: start=%0d done=%0d required 1/1", obsFs, obsFd);
    end
    checks++;
    if (FRAME_CNT !== 16'(expFc) || LINE_CNT !== 9'(mLine)) begin
      errors++; $display("FAIL basic_counts: FRAME_CNT=%0d LINE_CNT=%0d required %0d/%0d",
                         FRAME_CNT, LINE_CNT, expFc, mLine);
    end
    checks++;
    if (LB_BANK !== 1'(mWin % 2)) begin
      errors++; $display("FAIL basic_bank: got %b required %0d", LB_BANK, mWin % 2);
    end
  endtask

  task automatic test_crop_random();
    string msg; int m;
    for (int f = 0; f < 4; f++) begin
      case (f)
        1:       set_crop(20, 5, 0, 7);
        2:       set_crop(0, 30, 6, 2);
        default: set_crop($urandom_range(0, 25), $urandom_range(0, 30),
                          $urandom_range(0, 4), $urandom_range(0, 7));
      endcase
      clr_err();
      begin_test();
      CAPTURE_EN = 1'b1;
      vs_pulse();
      CAPTURE_EN = 1'b0;
      set_crop($urandom_range(0, 1000), $urandom_range(0, 1000), $urandom_range(0, 400), $urandom_range(0, 400));
      repeat ($urandom_range(4, 8)) send_line($urandom_range(16, 60), -1, 1'b0);
      vs_pulse();
      idle(5);
      m = wr_mismatch(msg); checks++;
      if (m != 0) begin errors++; $display("FAIL crop%0d_writes: %0d bad (%s), required 0", f, m, msg); end
      checks++;
      if (obsLd != expLd) begin errors++; $display("FAIL crop%0d_line_done: got %0d required %0d", f, obsLd, expLd); end
      checks++;
      if (ERR_PARTIAL !== expPart) begin
        errors++; $display("FAIL crop%0d_partial: got %b required %b", f, ERR_PARTIAL, expPart);
      end
      checks++;
      if (obsFd != 1 || FRAME_CNT !== 16'(expFc)) begin
        errors++; $display("FAIL crop%0d_frame: done=%0d cnt=%0d required 1/%0d", f, obsFd, FRAME_CNT, expFc);
      end
    end
  endtask

  task automatic test_ovf();
    string msg; int m;
    set_crop(100, 1200, 0, 0);
    clr_err();
    begin_test();
    CAPTURE_EN = 1'b1;
    vs_pulse();
    CAPTURE_EN = 1'b0;
    send_line(2560, -1, 1'b0);
    vs_pulse();
    idle(5);
    m = wr_mismatch(msg); checks++;
    if (m != 0) begin errors++; $display("FAIL ovf_writes: %0d bad (%s), required 0", m, msg); end
    checks++;
    if (obsQ.size() == 0 || obsQ[obsQ.size()-1].addr != 1023) begin
      errors++; $display("FAIL ovf_last_addr: writes=%0d required last addr 1023", obsQ.size());
    end
    checks++;
    if (ERR_OVF !== 1'b1 || !expOvf) begin
      errors++; $display("FAIL ovf_flag: got %b required 1", ERR_OVF);
    end
    clr_err();
    checks++;
    if (ERR_OVF !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b required 0", ERR_OVF); end
  endtask

  task automatic test_partial();
    string msg; int m;
    set_crop(0, 639, 0, 479);
    clr_err();
    begin_test();
    CAPTURE_EN = 1'b1;
    vs_pulse();
    CAPTURE_EN = 1'b0;
    send_line(5, -1, 1'b0);
    vs_pulse();
    idle(5);
    m = wr_mismatch(msg); checks++;
    if (m != 0 || obsQ.size() != 2) begin
      errors++; $display("FAIL partial_writes: %0d bad (%s), count %0d required 2", m, msg, obsQ.size());
    end
    checks++;
    if (ERR_PARTIAL !== 1'b1) begin errors++; $display("FAIL partial_flag: got %b required 1", ERR_PARTIAL); end
    clr_err();
    checks++;
    if (ERR_PARTIAL !== 1'b0) begin errors++; $display("FAIL partial_clear: got %b required 0", ERR_PARTIAL); end
  endtask

  task automatic test_abort();
    string msg; int m;
    set_crop(0, 639, 0, 479);
    begin_test();
    CAPTURE_EN = 1'b1;
    vs_pulse();
    send_line(640, -1, 1'b0);
    CAPTURE_EN = 1'b0;
    send_line(800, 300, 1'b0);
    vsLvl = 0; idle(3);
    send_line(40, -1, 1'b0);
    idle(5);
    m = wr_mismatch(msg); checks++;
    if (m != 0) begin errors++; $display("FAIL abort_writes: %0d bad (%s), required 0", m, msg); end
    checks++;
    if (obsLd != 1) begin errors++; $display("FAIL abort_line_done: got %0d required 1", obsLd); end
    checks++;
    if (obsFd != 1 || obsFs != 1) begin
      errors++; $display("FAIL abort_frame_pulses: start=%0d done=%0d required 1/1", obsFs, obsFd);
    end
    checks++;
    if (FRAME_CNT !== 16'(expFc)) begin errors++; $display("FAIL abort_frame_cnt: got %0d required %0d", FRAME_CNT, expFc); end
  endtask

  task automatic test_reset_mid();
    string msg; int m;
    set_crop(0, 639, 0, 479);
    begin_test();
    CAPTURE_EN = 1'b1;
    vs_pulse();
    send_line(40, -1, 1'b0);
    repeat (7) drive(1'b1, 8'($urandom_range(0, 255)));
    @(negedge PCLK);
    RST_N = 1'b0;
    #1;
    mActive = 0; expFc = 0; expPart = 0; expOvf = 0;
    checks++;
    if ({LB_WR_EN, LB_WR_ADDR, LB_WR_DATA, LB_BANK, LINE_DONE, FRAME_START, FRAME_DONE,
         LINE_CNT, FRAME_CNT, ERR_OVF, ERR_PARTIAL} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got nonzero (LINE_CNT=%0d FRAME_CNT=%0d) required all 0",
                         LINE_CNT, FRAME_CNT);
    end
    idle(3);
    RST_N = 1'b1;
    begin_test();
    send_line(40, -1, 1'b0);
    send_line(40, -1, 1'b0);
    checks++;
    if (obsQ.size() != 0 || obsFs != 0) begin
      errors++; $display("FAIL midreset_no_capture: writes=%0d starts=%0d required 0/0", obsQ.size(), obsFs);
    end
    vs_pulse();
    send_line(40, -1, 1'b0);
    idle(5);
    m = wr_mismatch(msg); checks++;
    if (m != 0) begin errors++; $display("FAIL midreset_writes: %0d bad (%s), required 0", m, msg); end
    checks++;
    if (obsFs != 1 || obsLd != 1) begin
      errors++; $display("FAIL midreset_resume: starts=%0d lines=%0d required 1/1", obsFs, obsLd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_crop_random();
    test_ovf();
    test_partial();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
